// File: rtl/calc_sm_sequencer_if.sv
// Handshake and converter bus for the sign-magnitude add/subtract sequencer.
// The master side is the surrounding system: operand entry, result consumer
// and the shared sign-magnitude/two's-complement converter.
interface calc_sm_sequencer_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a_sm;
    logic [W-1:0] b_sm;
    logic [W-1:0] conv_in;
    logic [W-1:0] conv_out;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sm;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, op, a_sm, b_sm, conv_out, res_ready,
        input  in_ready, conv_in, res_valid, res_sm, ovf, busy
    );

    modport slave (
        input  in_valid, op, a_sm, b_sm, conv_out, res_ready,
        output in_ready, conv_in, res_valid, res_sm, ovf, busy
    );
endinterface

// File: rtl/calc_sm_sequencer.sv
// Sequences one sign-magnitude add/subtract. A single external converter is
// time-shared: operand A in, operand B in, result out. Results that have no
// sign-magnitude encoding (|s| > 2^(W-1)-1) saturate and raise ovf.
module calc_sm_sequencer #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_sm_sequencer_if.slave   bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CONV_A = 3'd1;
    localparam logic [2:0] CONV_B = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] CONV_R = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    // Sign-magnitude -0; the converter would turn it into -2^(W-1).
    localparam logic [W-1:0] NEG_ZERO = {1'b1, {(W-1){1'b0}}};
    // Largest magnitude representable in sign-magnitude, in adder width.
    localparam logic signed [W:0] SM_MAX = $signed({2'b00, {(W-1){1'b1}}});
    localparam logic signed [W:0] SM_MIN = -SM_MAX;

    logic [2:0]          state;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                op_q;
    logic signed [W-1:0] ta;
    logic signed [W-1:0] tb;
    logic signed [W:0]   s_q;
    logic                ovf_q;
    logic [W-1:0]        res_q;

    logic [W-1:0]        a_norm;
    logic [W-1:0]        b_norm;
    logic signed [W:0]   s_next;
    logic                ovf_next;
    logic [W-1:0]        conv_in_c;

    assign a_norm = (a_q == NEG_ZERO) ? '0 : a_q;
    assign b_norm = (b_q == NEG_ZERO) ? '0 : b_q;

    // Adder/subtractor in W+1 bits so the true result and its range check are exact.
    always_comb begin
        if (op_q) begin
            s_next = (W+1)'(ta) - (W+1)'(tb);
        end else begin
            s_next = (W+1)'(ta) + (W+1)'(tb);
        end
        ovf_next = (s_next > SM_MAX) || (s_next < SM_MIN);
    end

    // Converter input select: one value per conversion phase, zero elsewhere.
    always_comb begin
        // NOTE: a default before the case keeps this purely combinational; a
        // path that leaves conv_in_c unassigned would infer a latch.
        conv_in_c = '0;
        case (state)
            CONV_A:  conv_in_c = a_norm;
            CONV_B:  conv_in_c = b_norm;
            CONV_R:  conv_in_c = ovf_q ? '0 : s_q[W-1:0];
            default: conv_in_c = '0;
        endcase
    end

    // Sequencer state and datapath registers.
    // NOTE: every register here, datapath included, is cleared by rst_n so an
    // aborted operation leaves nothing behind; there are no memories to exempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 1'b0;
            ta    <= '0;
            tb    <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
            res_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a_sm;
                        b_q   <= bus.b_sm;
                        op_q  <= bus.op;
                        state <= CONV_A;
                    end
                end
                CONV_A: begin
                    ta    <= bus.conv_out;
                    state <= CONV_B;
                end
                CONV_B: begin
                    tb    <= bus.conv_out;
                    state <= EXEC;
                end
                EXEC: begin
                    s_q   <= s_next;
                    ovf_q <= ovf_next;
                    state <= CONV_R;
                end
                CONV_R: begin
                    if (ovf_q) begin
                        res_q <= {s_q[W], {(W-1){1'b1}}};
                    end else begin
                        res_q <= bus.conv_out;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.res_sm    = res_q;
    assign bus.ovf       = ovf_q;
    assign bus.conv_in   = conv_in_c;
endmodule

// File: tb/tb_calc_sm_sequencer.sv
// Directed bench for calc_sm_sequencer. The bench models the external
// sign-magnitude/two's-complement converter; all expected values are hand-computed.
module tb_calc_sm_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    calc_sm_sequencer_if #(.W(W)) bus ();

    calc_sm_sequencer #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Converter: negative values negate the magnitude into W-1 bits, keeping the sign bit.
    function automatic logic [W-1:0] conv_model(input logic [W-1:0] x);
        logic [W-2:0] m;
        m = ~x[W-2:0] + 1'b1;
        return x[W-1] ? {1'b1, m} : x;
    endfunction

    assign bus.conv_out = conv_model(bus.conv_in);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set in IDLE; returns one step after the accepting edge (CONV_A).
    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic o);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a_sm     = a;
        bus.b_sm     = b;
        bus.op       = o;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    // Walk CONV_A..DONE checking the converter sequence and the 4-edge latency.
    task automatic run_to_done(input string tag, input logic [W-1:0] ca, input logic [W-1:0] cb,
                               input logic [W-1:0] cr, input logic [W-1:0] res, input logic ov);
        check({tag, "_conv_a"}, 32'(bus.conv_in), 32'(ca));
        check({tag, "_valid_a"}, 32'(bus.res_valid), 32'd0);
        tick();
        check({tag, "_conv_b"}, 32'(bus.conv_in), 32'(cb));
        tick();
        check({tag, "_conv_x"}, 32'(bus.conv_in), 32'd0);
        tick();
        check({tag, "_conv_r"}, 32'(bus.conv_in), 32'(cr));
        check({tag, "_valid_r"}, 32'(bus.res_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_res"}, 32'(bus.res_sm), 32'(res));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(ov));
        check({tag, "_conv_d"}, 32'(bus.conv_in), 32'd0);
        check({tag, "_ready_d"}, 32'(bus.in_ready), 32'd0);
    endtask

    // One-cycle result handshake, then back in IDLE.
    task automatic finish_op(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, "_valid_clr"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_ready_idle"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.a_sm      = '0;
        bus.b_sm      = '0;
        bus.res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res", 32'(bus.res_sm), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_conv", 32'(bus.conv_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // +5 + -3 = +2
        start_op("t1", 8'h05, 8'h83, 1'b0);
        run_to_done("t1", 8'h05, 8'h83, 8'h02, 8'h02, 1'b0);
        finish_op("t1");

        // 5 - 9 = -4
        start_op("t2a", 8'h05, 8'h09, 1'b1);
        run_to_done("t2a", 8'h05, 8'h09, 8'hFC, 8'h84, 1'b0);
        finish_op("t2a");

        // -5 - -5 = +0
        start_op("t2b", 8'h85, 8'h85, 1'b1);
        run_to_done("t2b", 8'h85, 8'h85, 8'h00, 8'h00, 1'b0);
        finish_op("t2b");

        // 100 + 50 saturates positive
        start_op("t3a", 8'h64, 8'h32, 1'b0);
        run_to_done("t3a", 8'h64, 8'h32, 8'h00, 8'h7F, 1'b1);
        finish_op("t3a");

        // -100 + -50 saturates negative
        start_op("t3b", 8'hE4, 8'hB2, 1'b0);
        run_to_done("t3b", 8'hE4, 8'hB2, 8'h00, 8'hFF, 1'b1);
        finish_op("t3b");

        // -1 + -127 = -128 has no sign-magnitude encoding
        start_op("t3c", 8'h81, 8'hFF, 1'b0);
        run_to_done("t3c", 8'h81, 8'hFF, 8'h00, 8'hFF, 1'b1);
        finish_op("t3c");

        // -0 + -0: both operands normalised to +0
        start_op("t4", 8'h80, 8'h80, 1'b0);
        run_to_done("t4", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        finish_op("t4");

        // Backpressure: 7 - -2 = 9, held in DONE while upstream toggles
        start_op("t5", 8'h07, 8'h82, 1'b1);
        run_to_done("t5", 8'h07, 8'h82, 8'h09, 8'h09, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a_sm     = 8'(i * 17);
            bus.b_sm     = 8'(255 - i * 13);
            bus.op       = i[1];
            tick();
            check("t5_hold_valid", 32'(bus.res_valid), 32'd1);
            check("t5_hold_res", 32'(bus.res_sm), 32'h09);
            check("t5_hold_ovf", 32'(bus.ovf), 32'd0);
            check("t5_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        finish_op("t5");
        // Next set accepted right away: -10 + 4 = -6
        start_op("t5n", 8'h8A, 8'h04, 1'b0);
        run_to_done("t5n", 8'h8A, 8'h04, 8'hFA, 8'h86, 1'b0);
        finish_op("t5n");

        // Asynchronous reset during EXEC
        start_op("t6", 8'h10, 8'h20, 1'b0);
        tick();
        tick();
        check("t6_exec_conv", 32'(bus.conv_in), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 32'(bus.in_ready), 32'd1);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_valid", 32'(bus.res_valid), 32'd0);
        check("t6_rst_res", 32'(bus.res_sm), 32'd0);
        check("t6_rst_ovf", 32'(bus.ovf), 32'd0);
        check("t6_rst_conv", 32'(bus.conv_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_valid", 32'(bus.res_valid), 32'd0);
            check("t6_idle", 32'(bus.in_ready), 32'd1);
        end
        start_op("t6f", 8'h01, 8'h01, 1'b0);
        run_to_done("t6f", 8'h01, 8'h01, 8'h02, 8'h02, 1'b0);
        finish_op("t6f");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
